lzss_stream_decoder: RTL and testbench
======================================

Name: lzss_stream_decoder

Overview:
- Parametrised, streaming LZSS decoder. Accepts literal and match tokens over a valid/ready handshake and emits one decoded symbol per cycle over a second valid/ready handshake.
- History is a circular window with read/write pointers, not a shift chain. Overlapping matches (offset < length) and output back-pressure are supported.
- Sits between the token parser and the byte sink in the decompression path.

Parameters:
- SYMBOL_LENGTH, 8: bits per decoded symbol.
- WINDOW_DEPTH, 256: history window entries. Power of two, at least 2.
- OFFSET_WIDTH, 16: token offset field width. Must be at least clog2(WINDOW_DEPTH)+1.
- LENGTH_WIDTH, 8: token length field width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  token valid.
- in_ready  out  1  decoder can accept a token this cycle.
- in_literal  in  1  1 = literal token, 0 = match token.
- in_data  in  SYMBOL_LENGTH  literal symbol (ignored for matches).
- in_offset  in  OFFSET_WIDTH  match distance back; 1 = most recent symbol.
- in_length  in  LENGTH_WIDTH  match symbol count.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- out_data  out  SYMBOL_LENGTH  decoded symbol.
- busy  out  1  high while in COPY state.

Behaviour:
- Reset values (while rst_=0):
  - in_ready=0, out_valid=0, out_data=0, busy=0.
  - state=IDLE, wr_ptr=0, remaining=0.
  - All window entries = 0.
  - in_ready rises on the first cycle after rst_ deasserts.
  - Reset mid-match aborts the match; no further symbols are emitted.
- Output register is a single stage. It can load when out_empty_or_taken = !out_valid || out_ready.
  - out_valid/out_data hold stable while out_valid=1 and out_ready=0.
- in_ready = (state==IDLE) && out_empty_or_taken. A token transfers when in_valid && in_ready.
- IDLE, literal accepted in cycle N:
  - In cycle N+1: out_data=in_data, out_valid=1.
  - window[wr_ptr] written with in_data; wr_ptr increments.
  - Back-to-back literals sustain 1 symbol/cycle.
- IDLE, match accepted with in_length=0: token consumed, no output, stays IDLE.
- IDLE, match accepted with in_length=L>0:
  - Latch rd_ptr = wr_ptr - in_offset (mod WINDOW_DEPTH) and remaining=L.
  - Go to COPY; in_ready=0.
- COPY, each cycle with out_empty_or_taken:
  - sym = window[rd_ptr], read combinationally.
  - Write window[wr_ptr]=sym and load the output register with sym.
  - Increment rd_ptr and wr_ptr; decrement remaining.
  - When remaining reaches 0, return to IDLE in the same cycle. in_ready may assert the following cycle.
- COPY stall: a cycle without out_empty_or_taken does no pointer, window or count update.
- Match latency: accepted in cycle N; first symbol out_valid in cycle N+2; then one symbol per accepted output cycle.
- Overlap: offset 1..L-1 re-reads symbols written earlier in the same match. Offset 1 with L=k repeats the last symbol k times.
- Pointer arithmetic is modulo WINDOW_DEPTH; wrap-around is seamless.
- Offsets larger than the number of symbols decoded since reset return stale or zero window contents. This is not detected (see the optional feature).
- Offset values 0 and > WINDOW_DEPTH: without the macro, the offset is truncated to clog2(WINDOW_DEPTH) bits, so 0 aliases WINDOW_DEPTH.
- in_literal/in_data/in_offset/in_length are sampled only on transfer.

Optional Feature:
- Macro LZSS_OFFSET_CHECK_EN.
- With the macro defined:
  - Adds output port err (1 bit, reset 0, sticky until reset).
  - Adds a saturating history counter of decoded symbols, capped at WINDOW_DEPTH.
  - A match with in_offset==0, in_offset>WINDOW_DEPTH, or in_offset>history is consumed with no output, sets err=1, and stays IDLE.
  - Literals continue normally after err is set.
- Without the macro: no err port, no counter; offsets are handled as described in Behaviour.

Test Plan:
- Literals A,B,C (0x41,0x42,0x43) back-to-back, out_ready=1 -> out 41,42,43 on consecutive cycles, each one cycle after its transfer.
- Literals 41,42,43 then match offset=3 length=6 -> out 41,42,43,41,42,43,41,42,43; busy high for 6 output cycles.
- Literal 0x5A then match offset=1 length=4 (overlap) -> out 5A,5A,5A,5A,5A; in_ready=0 during COPY.
- Match offset=2 length=4 after literals 01,02 with out_ready toggling 1,0,1,0 -> output 01,02,01,02 with no loss or duplication; out_data stable while stalled.
- 300 literals (i mod 256) then match offset=256 length=2 with WINDOW_DEPTH=256 -> out 0x2C,0x2D (wrap-around correct). Then rst_ pulse mid-match -> out_valid=0 immediately, in_ready=1 the cycle after release.
- LZSS_OFFSET_CHECK_EN defined: 2 literals then match offset=5 length=3 -> no output, err=1. A following literal 0x77 is still output as 77.

Source files
------------

// File: rtl/lzss_stream_decoder.sv
// Streaming LZSS decoder: literal/match tokens in, one symbol per cycle out.
// History is a circular window addressed by read/write pointers.
//
// Ports:
//   clk, rst_                  clock, async active-low reset
//   in_valid/in_ready          token handshake
//   in_literal, in_data        literal flag and literal symbol
//   in_offset, in_length       match distance (1 = last symbol) and count
//   out_valid/out_ready        symbol handshake
//   out_data                   decoded symbol
//   busy                       high while copying a match
//   err                        sticky bad-offset flag (LZSS_OFFSET_CHECK_EN only)
//
// Optional macro: LZSS_OFFSET_CHECK_EN adds err and a history counter so
// matches reaching before the decoded history are dropped and flagged.
module lzss_stream_decoder #(
    parameter int SYMBOL_LENGTH = 8,
    parameter int WINDOW_DEPTH  = 256,
    parameter int OFFSET_WIDTH  = 16,
    parameter int LENGTH_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_literal,
    input  logic [SYMBOL_LENGTH-1:0] in_data,
    input  logic [OFFSET_WIDTH-1:0]  in_offset,
    input  logic [LENGTH_WIDTH-1:0]  in_length,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SYMBOL_LENGTH-1:0] out_data,
    output logic                     busy
`ifdef LZSS_OFFSET_CHECK_EN
    ,
    output logic                     err
`endif
);

    localparam int AW = $clog2(WINDOW_DEPTH);

    typedef enum logic {IDLE, COPY} state_t;

    state_t                   state;
    logic [SYMBOL_LENGTH-1:0] window [WINDOW_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [LENGTH_WIDTH-1:0]  remaining;
    logic                     run;

    logic                     out_empty_or_taken;
    logic                     accept;
    logic                     lit_go;
    logic                     copy_go;
    logic                     we;
    logic                     bad_off;
    logic [SYMBOL_LENGTH-1:0] sym;
    logic [SYMBOL_LENGTH-1:0] wdata;

    // run holds in_ready low through reset and rises one edge after release.
    assign out_empty_or_taken = !out_valid || out_ready;
    assign in_ready = run && (state == IDLE) && out_empty_or_taken;
    assign accept   = in_valid && in_ready;
    assign lit_go   = accept && in_literal;
    assign copy_go  = (state == COPY) && out_empty_or_taken;
    assign sym      = window[rd_ptr];
    assign we       = lit_go || copy_go;
    assign wdata    = lit_go ? in_data : sym;

`ifdef LZSS_OFFSET_CHECK_EN
    logic [AW:0] hist;

    assign bad_off = (in_offset == '0)
                  || (in_offset > OFFSET_WIDTH'(WINDOW_DEPTH))
                  || (in_offset > OFFSET_WIDTH'(hist));

    // Symbols decoded since reset, saturating at the window depth.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            hist <= '0;
        end else if (we && (hist != (AW+1)'(WINDOW_DEPTH))) begin
            hist <= hist + 1'b1;
        end
    end
`else
    logic unused_offset_bits;

    // Offset is taken modulo the window, so 0 aliases WINDOW_DEPTH.
    assign bad_off = 1'b0;
    assign unused_offset_bits = ^in_offset[OFFSET_WIDTH-1:AW];
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < WINDOW_DEPTH; i++) begin
                window[i] <= '0;
            end
        end else if (we) begin
            window[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            run       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
`ifdef LZSS_OFFSET_CHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            run <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (lit_go) begin
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                        wr_ptr    <= wr_ptr + 1'b1;
                    end else if (accept) begin
                        out_valid <= 1'b0;
                        if (bad_off) begin
`ifdef LZSS_OFFSET_CHECK_EN
                            err <= 1'b1;
`endif
                        end else if (in_length != '0) begin
                            rd_ptr    <= wr_ptr - in_offset[AW-1:0];
                            remaining <= in_length;
                            state     <= COPY;
                            busy      <= 1'b1;
                        end
                    end else if (out_empty_or_taken) begin
                        out_valid <= 1'b0;
                    end
                end
                COPY: begin
                    // A stalled sink freezes pointers, window and count.
                    if (copy_go) begin
                        out_valid <= 1'b1;
                        out_data  <= sym;
                        rd_ptr    <= rd_ptr + 1'b1;
                        wr_ptr    <= wr_ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LENGTH_WIDTH'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lzss_stream_decoder.sv
// Directed scoreboard bench for lzss_stream_decoder.
// Expected symbols come from a reference history model.
module tb_lzss_stream_decoder;

    logic        clk;
    logic        rst_;
    logic        in_valid;
    logic        in_ready;
    logic        in_literal;
    logic [7:0]  in_data;
    logic [15:0] in_offset;
    logic [7:0]  in_length;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
`ifdef LZSS_OFFSET_CHECK_EN
    logic        err;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  model[$];
    bit          stalled = 0;
    logic [7:0]  prev_d;

    lzss_stream_decoder #(
        .SYMBOL_LENGTH(8),
        .WINDOW_DEPTH (256),
        .OFFSET_WIDTH (16),
        .LENGTH_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_literal(in_literal),
        .in_data   (in_data),
        .in_offset (in_offset),
        .in_length (in_length),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef LZSS_OFFSET_CHECK_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each accepted symbol and
    // checks that a stalled symbol holds steady.
    always @(negedge clk) begin
        if (stalled) begin
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_data", {24'b0, out_data}, {24'b0, prev_d});
        end
        stalled = 0;
        if (rst_ && out_valid) begin
            if (out_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_out observed=%0h expected=none",
                           out_data);
                end
                if (exp_q.size() != 0) begin
                    chk("out_data", {24'b0, out_data},
                        {24'b0, exp_q.pop_front()});
                end
            end else begin
                stalled = 1;
                prev_d  = out_data;
            end
        end
    end

    task automatic send(input bit lit, input logic [7:0] d,
                        input int off, input int len);
        int   n = 0;
        bit   got = 0;
        logic [7:0] b;
        in_valid   = 1'b1;
        in_literal = lit;
        in_data    = d;
        in_offset  = off[15:0];
        in_length  = len[7:0];
        while (!got && n < 200) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk("accept", {31'b0, got}, 32'd1);
        if (lit) begin
            model.push_back(d);
            exp_q.push_back(d);
        end else if (off >= 1 && off <= 256 && off <= model.size()) begin
            for (int k = 0; k < len; k++) begin
                b = model[model.size() - off];
                model.push_back(b);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        int bc;
        rst_       = 1'b0;
        in_valid   = 1'b0;
        in_literal = 1'b0;
        in_data    = '0;
        in_offset  = '0;
        in_length  = '0;
        out_ready  = 1'b1;

        #2;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, out_data}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

        // Back-to-back literals, one cycle latency each.
        send(1, 8'h41, 0, 0);
        chk("lit_a", {23'b0, out_valid, out_data}, {23'b0, 1'b1, 8'h41});
        send(1, 8'h42, 0, 0);
        chk("lit_b", {23'b0, out_valid, out_data}, {23'b0, 1'b1, 8'h42});
        send(1, 8'h43, 0, 0);
        chk("lit_c", {23'b0, out_valid, out_data}, {23'b0, 1'b1, 8'h43});
        drain();

        // Repeat-by-3 match: two-cycle latency, six busy cycles.
        send(1, 8'h41, 0, 0);
        send(1, 8'h42, 0, 0);
        send(1, 8'h43, 0, 0);
        send(0, 8'h00, 3, 6);
        chk("match_n1_idle", {31'b0, out_valid}, 32'd0);
        bc = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (k == 0) chk("copy_in_ready", {31'b0, in_ready}, 32'd0);
            if (k == 1) chk("match_first",
                            {23'b0, out_valid, out_data},
                            {23'b0, 1'b1, 8'h41});
        end
        chk("busy_cycles", bc, 32'd6);
        drain();

        // Overlapping match repeats the last symbol.
        send(1, 8'h5A, 0, 0);
        send(0, 8'h00, 1, 4);
        @(negedge clk);
        chk("overlap_in_ready", {31'b0, in_ready}, 32'd0);
        chk("overlap_busy", {31'b0, busy}, 32'd1);
        drain();

        // Back-pressure during a copy.
        send(1, 8'h01, 0, 0);
        send(1, 8'h02, 0, 0);
        send(0, 8'h00, 2, 4);
        for (int k = 0; k < 10; k++) begin
            out_ready = (k % 2 == 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // Window wrap-around.
        for (int i = 0; i < 300; i++) send(1, i[7:0], 0, 0);
        send(0, 8'h00, 256, 2);
        @(posedge clk);
        #1;
        chk("wrap_0", {23'b0, out_valid, out_data}, {23'b0, 1'b1, 8'h2C});
        @(posedge clk);
        #1;
        chk("wrap_1", {23'b0, out_valid, out_data}, {23'b0, 1'b1, 8'h2D});
        drain();

        // Reset in the middle of a long match.
        send(1, 8'h10, 0, 0);
        send(0, 8'h00, 1, 100);
        repeat (5) @(posedge clk);
        #1;
        rst_ = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        exp_q.delete();
        model.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_release_ready", {31'b0, in_ready}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_no_more", {31'b0, out_valid}, 32'd0);
        send(1, 8'h99, 0, 0);
        drain();

`ifdef LZSS_OFFSET_CHECK_EN
        rst_ = 1'b0;
        exp_q.delete();
        model.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        send(1, 8'h11, 0, 0);
        send(1, 8'h22, 0, 0);
        send(0, 8'h00, 5, 3);
        repeat (4) @(posedge clk);
        #1;
        chk("bad_off_err", {31'b0, err}, 32'd1);
        chk("bad_off_busy", {31'b0, busy}, 32'd0);
        send(1, 8'h77, 0, 0);
        chk("after_err_lit", {23'b0, out_valid, out_data},
            {23'b0, 1'b1, 8'h77});
        drain();
        chk("err_sticky", {31'b0, err}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
